lbus_master: RTL and testbench

Local-bus initiator that drives the 16-bit multiplexed address/data bus of the SASEBO-GIII cipher FPGA from the control side. Accepts single write/read commands over a valid/ready interface and sequences the address phase, write-data or read-strobe pulse, and bus turnaround. Used in the control FPGA and as the bus driver in chip-level benches against the cipher-side bus interface.

---
 rtl/lbus_master_if.sv | 27 ++
 rtl/lbus_master.sv | 193 +++++++++++++++++++
 tb/tb_lbus_master.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbus_master_if.sv
// Command/response handshake and multiplexed 16-bit local-bus signals of lbus_master.
interface lbus_master_if;
    localparam int unsigned DW = 16;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [DW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [DW-1:0] lbus_di_a;
    logic [DW-1:0] lbus_do;
    logic          lbus_wrn;
    logic          lbus_rdn;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, lbus_do,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, lbus_di_a, lbus_wrn, lbus_rdn
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, lbus_do,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, lbus_di_a, lbus_wrn, lbus_rdn
    );
endinterface

// File: rtl/lbus_master.sv
// Local-bus initiator: sequences address phase, write/read strobe pulse and turnaround gap.
// Define LBUS_MASTER_RDBACK_EN to read back every write and flag mismatches on rsp_err.
module lbus_master #(
    parameter int unsigned T_ADDR  = 2,
    parameter int unsigned T_PULSE = 2,
    parameter int unsigned T_GAP   = 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    lbus_master_if.master bus
);
    localparam int unsigned DW    = 16;
    localparam int unsigned T_AP  = (T_ADDR > T_PULSE) ? T_ADDR : T_PULSE;
    localparam int unsigned T_MAX = (T_AP > T_GAP) ? T_AP : T_GAP;
    localparam int unsigned CNT_W = $clog2(T_MAX) + 1;

`ifdef LBUS_MASTER_RDBACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WPULSE, S_RPULSE, S_GAP, S_RBADDR, S_RBPULSE
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WPULSE, S_RPULSE, S_GAP
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [DW-1:0]     di_a_q, di_a_d;
    logic              wrn_q, wrn_d;
    logic              rdn_q, rdn_d;
`ifdef LBUS_MASTER_RDBACK_EN
    logic [DW-1:0]     addr_q, addr_d;
    logic              err_q, err_d;
`endif
    logic              cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // State and registered outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            di_a_q  <= '0;
            wrn_q   <= 1'b1;
            rdn_q   <= 1'b1;
`ifdef LBUS_MASTER_RDBACK_EN
            addr_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            di_a_q  <= di_a_d;
            wrn_q   <= wrn_d;
            rdn_q   <= rdn_d;
`ifdef LBUS_MASTER_RDBACK_EN
            addr_q  <= addr_d;
            err_q   <= err_d;
`endif
        end
    end

    // Next state and next output values; strobes default to inactive
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        wr_d    = wr_q;
        wdata_d = wdata_q;
        ready_d = 1'b0;
        valid_d = 1'b0;
        rdata_d = rdata_q;
        di_a_d  = di_a_q;
        wrn_d   = 1'b1;
        rdn_d   = 1'b1;
`ifdef LBUS_MASTER_RDBACK_EN
        addr_d  = addr_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.cmd_valid && ready_q) begin
                    wr_d    = bus.cmd_wr;
                    wdata_d = bus.cmd_wdata;
                    di_a_d  = bus.cmd_addr;
`ifdef LBUS_MASTER_RDBACK_EN
                    addr_d  = bus.cmd_addr;
`endif
                    cnt_d   = CNT_W'(T_ADDR - 1);
                    ready_d = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cnt_zero) begin
                    cnt_d = CNT_W'(T_PULSE - 1);
                    if (wr_q) begin
                        di_a_d  = wdata_q;
                        wrn_d   = 1'b0;
                        state_d = S_WPULSE;
                    end else begin
                        rdn_d   = 1'b0;
                        state_d = S_RPULSE;
                    end
                end
            end
            S_WPULSE: begin
                wrn_d = 1'b0;
                if (cnt_zero) begin
                    wrn_d = 1'b1;
`ifdef LBUS_MASTER_RDBACK_EN
                    di_a_d  = addr_q;
                    cnt_d   = CNT_W'(T_ADDR - 1);
                    state_d = S_RBADDR;
`else
                    valid_d = 1'b1;
                    cnt_d   = CNT_W'(T_GAP - 1);
                    state_d = S_GAP;
`endif
                end
            end
            S_RPULSE: begin
                rdn_d = 1'b0;
                if (cnt_zero) begin
                    rdn_d   = 1'b1;
                    rdata_d = bus.lbus_do;
                    valid_d = 1'b1;
                    cnt_d   = CNT_W'(T_GAP - 1);
                    state_d = S_GAP;
                end
            end
`ifdef LBUS_MASTER_RDBACK_EN
            S_RBADDR: begin
                if (cnt_zero) begin
                    rdn_d   = 1'b0;
                    cnt_d   = CNT_W'(T_PULSE - 1);
                    state_d = S_RBPULSE;
                end
            end
            S_RBPULSE: begin
                rdn_d = 1'b0;
                if (cnt_zero) begin
                    rdn_d   = 1'b1;
                    rdata_d = bus.lbus_do;
                    err_d   = (bus.lbus_do != wdata_q);
                    valid_d = 1'b1;
                    cnt_d   = CNT_W'(T_GAP - 1);
                    state_d = S_GAP;
                end
            end
`endif
            S_GAP: begin
                if (cnt_zero) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.lbus_di_a = di_a_q;
    assign bus.lbus_wrn  = wrn_q;
    assign bus.lbus_rdn  = rdn_q;
`ifdef LBUS_MASTER_RDBACK_EN
    assign bus.rsp_err   = err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lbus_master.sv
// Scoreboard bench for lbus_master: random commands against a register-file target and reference model.
module tb_lbus_master;
    localparam int unsigned T_ADDR  = 2;
    localparam int unsigned T_PULSE = 2;
    localparam int unsigned T_GAP   = 1;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] val;
    } pulse_t;

    logic CLK = 1'b0;
    logic RSTn;
    logic corrupt_en;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    rsp_t   rsp_q[$];
    pulse_t pulse_q[$];

    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] last_rdata;

    logic [15:0] tgt_mem [logic [15:0]];
    logic [15:0] tgt_addr;
    logic [15:0] tgt_do;

    lbus_master_if bus ();

    lbus_master #(.T_ADDR(T_ADDR), .T_PULSE(T_PULSE), .T_GAP(T_GAP)) u_dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Target register file: latches address while both strobes high, stores on write strobe
    always @(posedge CLK) begin
        if (!RSTn) tgt_mem[16'h0180] = 16'hA5C3;
        if (bus.lbus_wrn && bus.lbus_rdn) tgt_addr = bus.lbus_di_a;
        else if (!bus.lbus_wrn) tgt_mem[tgt_addr] = bus.lbus_di_a;
    end

    always @(negedge CLK) begin
        if (!bus.lbus_rdn)
            tgt_do = (tgt_mem.exists(tgt_addr) ? tgt_mem[tgt_addr] : 16'h0000) ^ {15'b0, corrupt_en};
        else
            tgt_do = 16'h0000;
    end
    assign bus.lbus_do = tgt_do;

    // Response monitor
    always @(negedge CLK) begin
        rsp_t r;
        if (RSTn && bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, r.rdata);
                chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, r.err});
                chk("rsp_cycle", cyc, r.cyc);
            end
        end
    end

    // Strobe monitor: pulse kind/value/length, address phase, data stability, no overlap
    logic [15:0] hold [2];
    int          run [2] = '{0, 0};
    int          high_run = 0;
    logic [15:0] prev_di_a = '0;
    always @(negedge CLK) begin
        logic   lo [2];
        pulse_t p;
        if (!RSTn) begin
            run[0] = 0; run[1] = 0; high_run = 0;
        end else begin
            lo[0] = !bus.lbus_wrn;
            lo[1] = !bus.lbus_rdn;
            if (lo[0] || lo[1]) chk("strobe_overlap", {31'b0, lo[0] && lo[1]}, 32'd0);
            for (int k = 0; k < 2; k++) begin
                if (lo[k]) begin
                    if (run[k] == 0) begin
                        if (pulse_q.size() == 0) begin
                            chk("unexpected_pulse", 32'd1, 32'd0);
                        end else begin
                            p = pulse_q.pop_front();
                            chk("pulse_kind", {31'b0, k == 0}, {31'b0, p.wr});
                            chk("addr_phase_value", prev_di_a, p.addr);
                            chk("pulse_value", bus.lbus_di_a, p.val);
                        end
                        chk("addr_phase_len", {31'b0, high_run >= int'(T_ADDR)}, 32'd1);
                        hold[k] = bus.lbus_di_a;
                    end else begin
                        chk("pulse_data_stable", bus.lbus_di_a, hold[k]);
                    end
                    run[k]++;
                end else if (run[k] != 0) begin
                    chk("pulse_len", run[k], T_PULSE);
                    run[k] = 0;
                end
            end
            high_run = (lo[0] || lo[1]) ? 0 : high_run + 1;
            prev_di_a = bus.lbus_di_a;
        end
    end

    // Present a command (called at a negedge), queue its expectations, wait until ready returns
    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        int     n;
        int     c;
        int     len;
        rsp_t   r;
        pulse_t p;
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        n = 0;
        while (!bus.cmd_ready && n < 64) begin @(negedge CLK); n++; end
        if (!bus.cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
        len = T_ADDR + T_PULSE + T_GAP + 1;
        r.err = 1'b0;
        p.addr = addr;
        if (wr) begin
            p.wr = 1'b1; p.val = wdata; pulse_q.push_back(p);
            ref_mem[addr] = wdata;
`ifdef LBUS_MASTER_RDBACK_EN
            p.wr = 1'b0; p.val = addr; pulse_q.push_back(p);
            last_rdata = wdata ^ {15'b0, corrupt_en};
            r.err = corrupt_en;
            len += T_ADDR + T_PULSE;
`endif
        end else begin
            p.wr = 1'b0; p.val = addr; pulse_q.push_back(p);
            last_rdata = ref_mem.exists(addr) ? ref_mem[addr] : 16'h0000;
        end
        r.rdata = last_rdata;
        r.cyc   = cyc + len - int'(T_GAP);
        rsp_q.push_back(r);
        c = cyc;
        @(negedge CLK);
        n = 0;
        while (!bus.cmd_ready && n < 64) begin @(negedge CLK); n++; end
        chk("accept_to_ready", cyc - c, len);
    endtask

    initial begin
        int     n;
        int     gap;
        pulse_t p;
        RSTn          = 1'b0;
        corrupt_en    = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        ref_mem[16'h0180] = 16'hA5C3;
        last_rdata    = '0;

        // Reset held with cmd_valid toggling
        repeat (4) begin
            @(negedge CLK);
            bus.cmd_valid = ~bus.cmd_valid;
            chk("rst_wrn", {31'b0, bus.lbus_wrn}, 32'd1);
            chk("rst_rdn", {31'b0, bus.lbus_rdn}, 32'd1);
            chk("rst_di_a", bus.lbus_di_a, 32'd0);
            chk("rst_ready", {31'b0, bus.cmd_ready}, 32'd0);
            chk("rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
            chk("rst_rdata", bus.rsp_rdata, 32'd0);
            chk("rst_err", {31'b0, bus.rsp_err}, 32'd0);
        end
        bus.cmd_valid = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        chk("ready_at_release", {31'b0, bus.cmd_ready}, 32'd0);
        @(negedge CLK);
        chk("ready_after_release", {31'b0, bus.cmd_ready}, 32'd1);

        issue(1'b1, 16'h0002, 16'h0001);
        bus.cmd_valid = 1'b0;
        issue(1'b0, 16'h0180, 16'h0000);
        bus.cmd_valid = 1'b0;

        // Back-to-back with cmd_valid held
        issue(1'b1, 16'h0010, 16'hBEEF);
        issue(1'b0, 16'h0010, 16'h0000);
        issue(1'b1, 16'h0011, 16'h1357);
        bus.cmd_valid = 1'b0;

        repeat (40) begin
            issue(1'($urandom_range(0, 1)), {12'h000, 4'($urandom)}, 16'($urandom));
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                bus.cmd_valid = 1'b0;
                repeat (gap) @(negedge CLK);
            end
        end
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset asserted during the write pulse
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = 1'b1;
        bus.cmd_addr  = 16'h0F0F;
        bus.cmd_wdata = 16'h7777;
        p.wr = 1'b1; p.addr = 16'h0F0F; p.val = 16'h7777;
        pulse_q.push_back(p);
        @(negedge CLK);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (bus.lbus_wrn && n < 16) begin @(negedge CLK); n++; end
        chk("wpulse_reached", {31'b0, bus.lbus_wrn}, 32'd0);
        RSTn = 1'b0;
        #1;
        chk("abort_wrn_async", {31'b0, bus.lbus_wrn}, 32'd1);
        chk("abort_rdn", {31'b0, bus.lbus_rdn}, 32'd1);
        chk("abort_ready", {31'b0, bus.cmd_ready}, 32'd0);
        pulse_q.delete();
        last_rdata = '0;
        repeat (3) @(negedge CLK);
        chk("abort_rdata_cleared", bus.rsp_rdata, 32'd0);
        RSTn = 1'b1;
        @(negedge CLK);
        chk("ready_after_abort", {31'b0, bus.cmd_ready}, 32'd1);
        issue(1'b0, 16'h0F0F, 16'h0000);
        bus.cmd_valid = 1'b0;
        issue(1'b0, 16'h0180, 16'h0000);
        bus.cmd_valid = 1'b0;

`ifdef LBUS_MASTER_RDBACK_EN
        corrupt_en = 1'b1;
        issue(1'b1, 16'h1234, 16'h1234);
        bus.cmd_valid = 1'b0;
        corrupt_en = 1'b0;
        issue(1'b1, 16'h1234, 16'h1234);
        bus.cmd_valid = 1'b0;
`endif

        repeat (10) @(negedge CLK);
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        chk("pulse_queue_drained", pulse_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
